// File: rtl/sp_ram_be_clr.sv
// Single-port RAM with byte-lane write enables, selectable read-during-write, 1/2-cycle read latency and a clear engine.
// Optional macro SP_RAM_PARITY_EN adds per-lane even parity storage and the par_err output.
module sp_ram_be_clr #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned WRITE_MODE = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic                             we,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be,
    input  logic [ADDR_WIDTH-1:0]            addr,
    input  logic [DATA_WIDTH-1:0]            din,
    input  logic                             clr,
    output logic [DATA_WIDTH-1:0]            dout,
    output logic                             dout_valid,
`ifdef SP_RAM_PARITY_EN
    output logic                             par_err,
`endif
    output logic                             busy
);

    localparam int unsigned NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned PW    = ADDR_WIDTH + 1;

    if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_bad_latency
        $error("sp_ram_be_clr: RD_LATENCY must be 1 or 2");
    end
    if ((NB == 0) || (NB * BYTE_WIDTH != DATA_WIDTH)) begin : g_bad_width
        $error("sp_ram_be_clr: DATA_WIDTH must be a non-zero multiple of BYTE_WIDTH");
    end
    if (WRITE_MODE > 2) begin : g_bad_mode
        $error("sp_ram_be_clr: WRITE_MODE must be 0, 1 or 2");
    end

    typedef enum logic { CLEAR = 1'b0, READY = 1'b1 } state_t;

    state_t                state;
    logic [PW-1:0]         ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  acc_c;
    logic                  load_c;
    logic [DATA_WIDTH-1:0] old_c;
    logic [DATA_WIDTH-1:0] merged_c;
    logic [DATA_WIDTH-1:0] word_c;

    // Access qualification, byte-lane merge and the word a result slot carries
    always_comb begin
        acc_c    = en & ~busy;
        old_c    = mem[addr];
        merged_c = old_c;
        for (int unsigned i = 0; i < NB; i++) begin
            if (be[i]) begin
                merged_c[i*BYTE_WIDTH +: BYTE_WIDTH] = din[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        load_c = acc_c & (~we | (WRITE_MODE != 0));
        word_c = (we && (WRITE_MODE == 2)) ? merged_c : old_c;
    end

    // Clear engine: walks every address once, then serves accesses until clr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    ptr <= ptr + PW'(1);
                    if (ptr == PW'(DEPTH - 1)) begin
                        state <= READY;
                        busy  <= 1'b0;
                    end
                end
                READY: begin
                    if (clr) begin
                        state <= CLEAR;
                        ptr   <= '0;
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    state <= CLEAR;
                    ptr   <= '0;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[ptr[ADDR_WIDTH-1:0]] <= '0;
        end else if (acc_c && we) begin
            mem[addr] <= merged_c;
        end
    end

`ifdef SP_RAM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic [NB-1:0] par_old_c;
    logic [NB-1:0] par_new_c;
    logic [NB-1:0] lane_bad_c;
    logic          perr_c;

    // Unwritten lanes keep their stored parity so an earlier corruption stays visible
    always_comb begin
        par_old_c = par_mem[addr];
        for (int unsigned i = 0; i < NB; i++) begin
            lane_bad_c[i] = (^old_c[i*BYTE_WIDTH +: BYTE_WIDTH]) ^ par_old_c[i];
            par_new_c[i]  = be[i] ? (^din[i*BYTE_WIDTH +: BYTE_WIDTH]) : par_old_c[i];
        end
        perr_c = (we && (WRITE_MODE == 2)) ? |(lane_bad_c & ~be) : |lane_bad_c;
    end

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            par_mem[ptr[ADDR_WIDTH-1:0]] <= '0;
        end else if (acc_c && we) begin
            par_mem[addr] <= par_new_c;
        end
    end
`endif

    if (RD_LATENCY == 2) begin : g_lat2
        logic                  pipe_valid;
        logic [DATA_WIDTH-1:0] pipe_data;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pipe_valid <= 1'b0;
                pipe_data  <= '0;
                dout_valid <= 1'b0;
                dout       <= '0;
            end else begin
                pipe_valid <= load_c;
                dout_valid <= pipe_valid;
                if (load_c) begin
                    pipe_data <= word_c;
                end
                if (pipe_valid) begin
                    dout <= pipe_data;
                end
            end
        end

`ifdef SP_RAM_PARITY_EN
        logic pipe_perr;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pipe_perr <= 1'b0;
                par_err   <= 1'b0;
            end else begin
                pipe_perr <= load_c & perr_c;
                par_err   <= pipe_valid & pipe_perr;
            end
        end
`endif
    end else begin : g_lat1
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout_valid <= 1'b0;
                dout       <= '0;
            end else begin
                dout_valid <= load_c;
                if (load_c) begin
                    dout <= word_c;
                end
            end
        end

`ifdef SP_RAM_PARITY_EN
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                par_err <= 1'b0;
            end else begin
                par_err <= load_c & perr_c;
            end
        end
`endif
    end

endmodule

// File: tb/tb_sp_ram_be_clr.sv
// Bench for sp_ram_be_clr: four instances (latency / write-mode variants) share one stimulus stream.
// Parity checks are compiled in when SP_RAM_PARITY_EN is defined.
module tb_sp_ram_be_clr;

    localparam int NI    = 4;
    localparam int DEPTH = 16;
    localparam int HMAX  = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        we;
    logic [3:0]  be;
    logic [3:0]  addr;
    logic [31:0] din;
    logic        clr;

    logic [31:0] dout_w [NI];
    logic        dv_w   [NI];
    logic        busy_w [NI];
`ifdef SP_RAM_PARITY_EN
    logic        perr_w [NI];
`endif

    always #5 clk = ~clk;

    sp_ram_be_clr #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8), .RD_LATENCY(1), .WRITE_MODE(0)) u0 (
        .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .din(din), .clr(clr),
        .dout(dout_w[0]), .dout_valid(dv_w[0]),
`ifdef SP_RAM_PARITY_EN
        .par_err(perr_w[0]),
`endif
        .busy(busy_w[0]));

    sp_ram_be_clr #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8), .RD_LATENCY(1), .WRITE_MODE(1)) u1 (
        .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .din(din), .clr(clr),
        .dout(dout_w[1]), .dout_valid(dv_w[1]),
`ifdef SP_RAM_PARITY_EN
        .par_err(perr_w[1]),
`endif
        .busy(busy_w[1]));

    sp_ram_be_clr #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8), .RD_LATENCY(1), .WRITE_MODE(2)) u2 (
        .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .din(din), .clr(clr),
        .dout(dout_w[2]), .dout_valid(dv_w[2]),
`ifdef SP_RAM_PARITY_EN
        .par_err(perr_w[2]),
`endif
        .busy(busy_w[2]));

    sp_ram_be_clr #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8), .RD_LATENCY(2), .WRITE_MODE(2)) u3 (
        .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .din(din), .clr(clr),
        .dout(dout_w[3]), .dout_valid(dv_w[3]),
`ifdef SP_RAM_PARITY_EN
        .par_err(perr_w[3]),
`endif
        .busy(busy_w[3]));

    // Reference model: array contents, remaining busy cycles and a per-edge history of accepted accesses
    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] old_w;
        logic [31:0] new_w;
        logic        perr_old;
        logic        perr_new;
    } slot_t;

    slot_t       hist  [HMAX];
    logic [31:0] mem_m [DEPTH];
    logic [3:0]  bad_m [DEPTH];
    int          busy_cnt;
    int          edge_no;
    int          first_edge;
    logic [31:0] exp_dout [NI];
    logic        exp_dv   [NI];
    logic        exp_perr [NI];
    logic        exp_busy;
    int          n_chk;
    int          n_pass;

    function automatic int lat_of(input int k);
        return (k == 3) ? 2 : 1;
    endfunction

    function automatic int wm_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 2);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
        logic [31:0] m;
        m = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
        return (n & m) | (o & ~m);
    endfunction

    function automatic logic got_perr(input int k);
`ifdef SP_RAM_PARITY_EN
        return perr_w[k];
`else
        return (k < 0);
`endif
    endfunction

    task automatic model_reset();
        busy_cnt   = DEPTH;
        first_edge = edge_no;
        exp_busy   = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            mem_m[i] = '0;
            bad_m[i] = '0;
        end
        for (int k = 0; k < NI; k++) begin
            exp_dout[k] = '0;
            exp_dv[k]   = 1'b0;
            exp_perr[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        slot_t s;
        int    src;
        s = '0;
        if (en && busy_cnt == 0) begin
            s.old_w    = mem_m[addr];
            s.new_w    = merge(s.old_w, din, be);
            s.perr_old = |bad_m[addr];
            s.perr_new = |(bad_m[addr] & ~be);
            if (we) begin
                s.wr        = 1'b1;
                mem_m[addr] = s.new_w;
                bad_m[addr] = bad_m[addr] & ~be;
            end else begin
                s.rd = 1'b1;
            end
        end
        if (busy_cnt > 0) begin
            busy_cnt--;
        end else if (clr) begin
            busy_cnt = DEPTH;
            for (int i = 0; i < DEPTH; i++) begin
                mem_m[i] = '0;
                bad_m[i] = '0;
            end
        end
        hist[edge_no % HMAX] = s;
        for (int k = 0; k < NI; k++) begin
            src         = edge_no - lat_of(k) + 1;
            exp_dv[k]   = 1'b0;
            exp_perr[k] = 1'b0;
            if (src >= first_edge) begin
                s = hist[src % HMAX];
                if (s.rd || (s.wr && wm_of(k) != 0)) begin
                    exp_dv[k]   = 1'b1;
                    exp_dout[k] = (s.wr && wm_of(k) == 2) ? s.new_w : s.old_w;
                    exp_perr[k] = (s.wr && wm_of(k) == 2) ? s.perr_new : s.perr_old;
                end
            end
        end
        exp_busy = (busy_cnt != 0);
        edge_no++;
    endtask

    task automatic cyc(input logic e, input logic w, input logic [3:0] b, input logic [3:0] a,
                       input logic [31:0] d, input logic c);
        en = e; we = w; be = b; addr = a; din = d; clr = c;
        @(posedge clk);
        model_edge();
        #1;
        en = 1'b0; we = 1'b0; clr = 1'b0;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; we = 1'b0; be = '0; addr = '0; din = '0; clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        for (int k = 0; k < NI; k++) begin
            n_chk++;
            if (dv_w[k] !== 1'b0 || dout_w[k] !== 32'h0 || busy_w[k] !== 1'b1)
                $display("FAIL reset_state u%0d: got dv=%b dout=%h busy=%b, expected dv=0 dout=00000000 busy=1",
                         k, dv_w[k], dout_w[k], busy_w[k]);
            else n_pass++;
        end
        rst = 1'b0;
        for (int j = 1; j <= DEPTH; j++) begin
            logic eb;
            idle();
            eb = (j < DEPTH);
            n_chk++;
            if (busy_w[0] !== eb || busy_w[3] !== eb)
                $display("FAIL reset_busy cycle %0d: got busy=%b/%b, expected %b", j, busy_w[0], busy_w[3], eb);
            else n_pass++;
        end
    endtask

    task automatic test_clear_reads();
        for (int a = 0; a < DEPTH; a++) begin
            cyc(1'b1, 1'b0, 4'h0, 4'(a), 32'h0, 1'b0);
            n_chk++;
            if (dv_w[0] !== 1'b1 || dout_w[0] !== 32'h0)
                $display("FAIL cleared_read addr %0d: got dv=%b dout=%h, expected dv=1 dout=00000000", a, dv_w[0], dout_w[0]);
            else n_pass++;
        end
        idle();
        n_chk++;
        if (dv_w[0] !== 1'b0 || dv_w[3] !== 1'b1 || dout_w[3] !== 32'h0)
            $display("FAIL cleared_tail: got dv0=%b dv3=%b dout3=%h, expected dv0=0 dv3=1 dout3=00000000",
                     dv_w[0], dv_w[3], dout_w[3]);
        else n_pass++;
    endtask

    task automatic test_byte_enable();
        cyc(1'b1, 1'b1, 4'hF, 4'd3, 32'hAABBCCDD, 1'b0);
        cyc(1'b1, 1'b1, 4'h5, 4'd3, 32'h11223344, 1'b0);
        cyc(1'b1, 1'b0, 4'h0, 4'd3, 32'h0, 1'b0);
        n_chk++;
        if (dv_w[0] !== 1'b1 || dout_w[0] !== 32'hAA22CC44)
            $display("FAIL byte_enable_read: got dv=%b dout=%h, expected dv=1 dout=aa22cc44", dv_w[0], dout_w[0]);
        else n_pass++;
        cyc(1'b1, 1'b1, 4'h0, 4'd3, 32'hFFFFFFFF, 1'b0);
        n_chk++;
        if (dv_w[0] !== 1'b0 || dout_w[0] !== 32'hAA22CC44 || dv_w[2] !== 1'b1 || dout_w[2] !== 32'hAA22CC44)
            $display("FAIL be_zero_write: got dv0=%b dout0=%h dv2=%b dout2=%h, expected dv0=0 dout0=aa22cc44 dv2=1 dout2=aa22cc44",
                     dv_w[0], dout_w[0], dv_w[2], dout_w[2]);
        else n_pass++;
        cyc(1'b1, 1'b0, 4'h0, 4'd3, 32'h0, 1'b0);
        n_chk++;
        if (dout_w[0] !== 32'hAA22CC44)
            $display("FAIL be_zero_noop: got dout=%h, expected aa22cc44", dout_w[0]);
        else n_pass++;
    endtask

    task automatic test_write_modes();
        cyc(1'b1, 1'b1, 4'hF, 4'd5, 32'h12345678, 1'b0);
        cyc(1'b1, 1'b1, 4'hF, 4'd5, 32'hFFFFFFFF, 1'b0);
        n_chk++;
        if (dv_w[1] !== 1'b1 || dout_w[1] !== 32'h12345678)
            $display("FAIL read_first: got dv=%b dout=%h, expected dv=1 dout=12345678", dv_w[1], dout_w[1]);
        else n_pass++;
        n_chk++;
        if (dv_w[2] !== 1'b1 || dout_w[2] !== 32'hFFFFFFFF)
            $display("FAIL write_first: got dv=%b dout=%h, expected dv=1 dout=ffffffff", dv_w[2], dout_w[2]);
        else n_pass++;
        n_chk++;
        if (dv_w[0] !== 1'b0 || dout_w[0] !== 32'hAA22CC44)
            $display("FAIL no_change: got dv=%b dout=%h, expected dv=0 dout=aa22cc44", dv_w[0], dout_w[0]);
        else n_pass++;
        idle();
        n_chk++;
        if (dv_w[3] !== 1'b1 || dout_w[3] !== 32'hFFFFFFFF || dv_w[1] !== 1'b0 || dout_w[1] !== 32'h12345678)
            $display("FAIL write_first_lat2: got dv3=%b dout3=%h dv1=%b dout1=%h, expected dv3=1 dout3=ffffffff dv1=0 dout1=12345678",
                     dv_w[3], dout_w[3], dv_w[1], dout_w[1]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int a = 1; a <= 3; a++) cyc(1'b1, 1'b1, 4'hF, 4'(a), 32'(a), 1'b0);
        idle();
        idle();
        for (int j = 0; j < 5; j++) begin
            logic ev3;
            logic ev0;
            if (j < 3) cyc(1'b1, 1'b0, 4'h0, 4'(j + 1), 32'h0, 1'b0);
            else idle();
            ev3 = (j >= 1 && j <= 3);
            ev0 = (j <= 2);
            n_chk++;
            if (dv_w[3] !== ev3 || (ev3 && dout_w[3] !== 32'(j)))
                $display("FAIL lat2_pipeline edge %0d: got dv=%b dout=%h, expected dv=%b dout=%h",
                         j + 1, dv_w[3], dout_w[3], ev3, 32'(j));
            else n_pass++;
            n_chk++;
            if (dv_w[0] !== ev0 || (ev0 && dout_w[0] !== 32'(j + 1)))
                $display("FAIL lat1_pipeline edge %0d: got dv=%b dout=%h, expected dv=%b dout=%h",
                         j + 1, dv_w[0], dout_w[0], ev0, 32'(j + 1));
            else n_pass++;
        end
    endtask

    task automatic test_clr();
        cyc(1'b1, 1'b1, 4'hF, 4'd7, 32'hDEADBEEF, 1'b0);
        cyc(1'b1, 1'b0, 4'h0, 4'd7, 32'h0, 1'b1);
        n_chk++;
        if (dv_w[0] !== 1'b1 || dout_w[0] !== 32'hDEADBEEF || busy_w[0] !== 1'b1)
            $display("FAIL clr_same_cycle_read: got dv=%b dout=%h busy=%b, expected dv=1 dout=deadbeef busy=1",
                     dv_w[0], dout_w[0], busy_w[0]);
        else n_pass++;
        for (int j = 1; j <= DEPTH; j++) begin
            logic eb;
            cyc(1'b1, 1'b0, 4'h0, 4'd7, 32'h0, 1'b0);
            eb = (j < DEPTH);
            n_chk++;
            if (busy_w[0] !== eb || dv_w[0] !== 1'b0 || dv_w[1] !== 1'b0 || (j > 1 && dv_w[3] !== 1'b0))
                $display("FAIL clr_busy cycle %0d: got busy=%b dv0=%b dv1=%b dv3=%b, expected busy=%b dv=0",
                         j, busy_w[0], dv_w[0], dv_w[1], dv_w[3], eb);
            else n_pass++;
        end
        cyc(1'b1, 1'b0, 4'h0, 4'd7, 32'h0, 1'b0);
        n_chk++;
        if (dv_w[0] !== 1'b1 || dout_w[0] !== 32'h0)
            $display("FAIL clr_result: got dv=%b dout=%h, expected dv=1 dout=00000000", dv_w[0], dout_w[0]);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        cyc(1'b1, 1'b1, 4'hF, 4'd9, 32'h5A5A5A5A, 1'b0);
        cyc(1'b1, 1'b0, 4'h0, 4'd9, 32'h0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        for (int k = 0; k < NI; k++) begin
            n_chk++;
            if (dv_w[k] !== 1'b0 || dout_w[k] !== 32'h0 || busy_w[k] !== 1'b1)
                $display("FAIL async_reset u%0d: got dv=%b dout=%h busy=%b, expected dv=0 dout=00000000 busy=1",
                         k, dv_w[k], dout_w[k], busy_w[k]);
            else n_pass++;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int j = 0; j < 5; j++) begin
            cyc(1'b1, 1'b0, 4'h0, 4'd9, 32'h0, 1'b0);
            for (int k = 0; k < NI; k++) begin
                n_chk++;
                if (dv_w[k] !== exp_dv[k] || dout_w[k] !== exp_dout[k] || busy_w[k] !== exp_busy)
                    $display("FAIL reset_restart u%0d: got dv=%b dout=%h busy=%b, expected dv=%b dout=%h busy=%b",
                             k, dv_w[k], dout_w[k], busy_w[k], exp_dv[k], exp_dout[k], exp_busy);
                else n_pass++;
            end
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int j = 1; j <= DEPTH; j++) begin
            logic eb;
            idle();
            eb = (j < DEPTH);
            n_chk++;
            if (busy_w[2] !== eb)
                $display("FAIL mid_clear_reset cycle %0d: got busy=%b, expected %b", j, busy_w[2], eb);
            else n_pass++;
        end
    endtask

`ifdef SP_RAM_PARITY_EN
    task automatic test_parity();
        cyc(1'b1, 1'b1, 4'hF, 4'd2, 32'h12345678, 1'b0);
        cyc(1'b1, 1'b1, 4'hF, 4'd4, 32'hCAFEF00D, 1'b0);
        u0.mem[2] = u0.mem[2] ^ 32'h00000100;
        u1.mem[2] = u1.mem[2] ^ 32'h00000100;
        u2.mem[2] = u2.mem[2] ^ 32'h00000100;
        u3.mem[2] = u3.mem[2] ^ 32'h00000100;
        mem_m[2] = mem_m[2] ^ 32'h00000100;
        bad_m[2] = bad_m[2] | 4'b0010;
        cyc(1'b1, 1'b0, 4'h0, 4'd2, 32'h0, 1'b0);
        n_chk++;
        if (perr_w[0] !== 1'b1 || dv_w[0] !== 1'b1 || dout_w[0] !== 32'h12345778)
            $display("FAIL parity_error: got par_err=%b dv=%b dout=%h, expected par_err=1 dv=1 dout=12345778",
                     perr_w[0], dv_w[0], dout_w[0]);
        else n_pass++;
        cyc(1'b1, 1'b0, 4'h0, 4'd4, 32'h0, 1'b0);
        n_chk++;
        if (perr_w[0] !== 1'b0 || dv_w[0] !== 1'b1 || dout_w[0] !== 32'hCAFEF00D)
            $display("FAIL parity_clean: got par_err=%b dv=%b dout=%h, expected par_err=0 dv=1 dout=cafef00d",
                     perr_w[0], dv_w[0], dout_w[0]);
        else n_pass++;
        n_chk++;
        if (perr_w[3] !== 1'b1 || dv_w[3] !== 1'b1)
            $display("FAIL parity_lat2: got par_err=%b dv=%b, expected par_err=1 dv=1", perr_w[3], dv_w[3]);
        else n_pass++;
    endtask
`endif

    task automatic test_random();
        for (int j = 0; j < 400; j++) begin
            cyc(($urandom % 4) != 0, 1'($urandom), 4'($urandom), 4'($urandom), $urandom,
                ($urandom % 50) == 0);
            for (int k = 0; k < NI; k++) begin
                n_chk++;
                if (dv_w[k] !== exp_dv[k] || dout_w[k] !== exp_dout[k] || busy_w[k] !== exp_busy ||
                    got_perr(k) !== exp_perr[k])
                    $display("FAIL random u%0d step %0d: got dv=%b dout=%h busy=%b perr=%b, expected dv=%b dout=%h busy=%b perr=%b",
                             k, j, dv_w[k], dout_w[k], busy_w[k], got_perr(k),
                             exp_dv[k], exp_dout[k], exp_busy, exp_perr[k]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        edge_no = 0;
        test_reset();
        test_clear_reads();
        test_byte_enable();
        test_write_modes();
        test_back_to_back();
        test_clr();
        test_reset_mid();
`ifdef SP_RAM_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
